// File: rtl/pool_window_unit.sv
// pool_window_unit
// Per-PE pooling datapath fed by the pool controller's raster pixel stream.
// Produces one result per non-overlapping pool_horiz x pool_vert window,
// 1 cycle after the pixel that completes the window.
// A horizontal running value is kept in hmax_r. Partial column results for
// the current band of rows are kept in pbuf, one entry per window column.
// Trailing columns and rows that do not fill a whole window are dropped.
// Build option: define POOL_AVG_EN to add the pool_avg port.
//   With pool_avg=1, the max is replaced by a widened sum.
//   The sum is then scaled by >>> log2(window area).
module pool_window_unit #(
  parameter int DATA_W   = 16,
  parameter int MAX_ROW  = 64,
  parameter int MAX_POOL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pool_enable,
  input  logic              line_buffer_reset,
  input  logic              shift_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [15:0]       row_length,
  input  logic [7:0]        pool_horiz,
  input  logic [7:0]        pool_vert,
`ifdef POOL_AVG_EN
  input  logic              pool_avg,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [15:0]       out_cnt,
  output logic              cfg_err
);

  // Partial values are widened in average mode so a full 8x8 sum cannot overflow.
`ifdef POOL_AVG_EN
  localparam int PW = DATA_W + 6;
`else
  localparam int PW = DATA_W;
`endif
  localparam int          WCW        = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
  localparam logic [15:0] MAX_ROW_V  = 16'(MAX_ROW);
  localparam logic [7:0]  MAX_POOL_V = 8'(MAX_POOL);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  // Combine two partial values.
  // In sum mode the values are added; otherwise the signed maximum is kept.
  // Ties may return either operand, because both give the same value.
  function automatic logic signed [PW-1:0] merge(input logic signed [PW-1:0] a,
                                                 input logic signed [PW-1:0] b,
                                                 input logic             sum_mode);
    logic signed [PW-1:0] r;
    if (sum_mode) begin
      r = a + b;
    end else if (a > b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

`ifdef POOL_AVG_EN
  // Index of the highest set bit; equals log2 when the value is a power of two.
  function automatic logic [3:0] log2_pow2(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        r = 4'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction
`endif

  state_t               state_r;
  logic [15:0]          col_r;
  logic [7:0]           h_cnt_r;
  logic [7:0]           v_cnt_r;
  logic [WCW-1:0]       wcol_r;
  logic signed [PW-1:0] hmax_r;
  logic signed [PW-1:0] pbuf [0:MAX_ROW-1];

  logic                 sum_mode_s;
  logic                 cfg_ok_s;
  logic                 run_ok_s;
  logic                 accept_s;
  logic                 h_first_s;
  logic                 h_done_s;
  logic                 v_first_s;
  logic                 v_last_s;
  logic                 row_end_s;
  logic                 emit_s;
  logic signed [PW-1:0] pix_s;
  logic signed [PW-1:0] h_val_s;
  logic signed [PW-1:0] pbuf_rd_s;
  logic signed [PW-1:0] comb_s;
  logic signed [PW-1:0] scaled_s;
  logic [DATA_W-1:0]    result_s;
`ifdef POOL_AVG_EN
  logic [15:0]          area_s;
  logic [3:0]           area_log2_s;
`endif

  // Configuration legality check.
  // The result is sampled when line_buffer_reset drops.
  always_comb begin
    cfg_ok_s = 1'b1;
    if ((pool_horiz == 8'd0) || (pool_vert == 8'd0)) begin
      cfg_ok_s = 1'b0;
    end else if ((pool_horiz > MAX_POOL_V) || (pool_vert > MAX_POOL_V)) begin
      cfg_ok_s = 1'b0;
    end else if (row_length > MAX_ROW_V) begin
      cfg_ok_s = 1'b0;
    end else if (row_length < {8'd0, pool_horiz}) begin
      cfg_ok_s = 1'b0;
    end else begin
      cfg_ok_s = 1'b1;
    end
`ifdef POOL_AVG_EN
    sum_mode_s  = pool_avg;
    area_s      = {8'd0, pool_horiz} * {8'd0, pool_vert};
    area_log2_s = log2_pow2(area_s);
    // Averaging divides by a shift, so the window area must be a power of two.
    cfg_ok_s    = cfg_ok_s & ~(pool_avg & ((area_s & (area_s - 16'd1)) != 16'd0));
`else
    sum_mode_s  = 1'b0;
`endif
  end

  // Pixel acceptance, window position decode and the horizontal/vertical combine.
  always_comb begin
    // The first cycle after a legal clear already counts as running.
    // This avoids a dead cycle after line_buffer_reset drops.
    run_ok_s  = (state_r == ST_RUN) || ((state_r == ST_CLEAR) && cfg_ok_s);
    accept_s  = shift_in & pool_enable & ~line_buffer_reset & run_ok_s;
    h_first_s = (h_cnt_r == 8'd0);
    h_done_s  = (h_cnt_r == (pool_horiz - 8'd1));
    v_first_s = (v_cnt_r == 8'd0);
    v_last_s  = (v_cnt_r == (pool_vert - 8'd1));
    row_end_s = (col_r == (row_length - 16'd1));
    pix_s     = PW'($signed(data_in));
    pbuf_rd_s = pbuf[wcol_r];
    if (h_first_s) begin
      h_val_s = pix_s;
    end else begin
      h_val_s = merge(hmax_r, pix_s, sum_mode_s);
    end
    // On the top row of a band the buffered entry is stale and is ignored.
    // This also makes a pool_vert=1 result equal to the horizontal value.
    if (v_first_s) begin
      comb_s = h_val_s;
    end else begin
      comb_s = merge(pbuf_rd_s, h_val_s, sum_mode_s);
    end
`ifdef POOL_AVG_EN
    if (sum_mode_s) begin
      scaled_s = comb_s >>> area_log2_s;
    end else begin
      scaled_s = comb_s;
    end
`else
    scaled_s = comb_s;
`endif
    result_s = DATA_W'(scaled_s);
    emit_s   = accept_s & h_done_s & v_last_s;
  end

  // Control FSM, window counters, horizontal running value and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_CLEAR;
      col_r     <= 16'd0;
      h_cnt_r   <= 8'd0;
      v_cnt_r   <= 8'd0;
      wcol_r    <= {WCW{1'b0}};
      hmax_r    <= {PW{1'b0}};
      data_out  <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
      out_cnt   <= 16'd0;
      cfg_err   <= 1'b0;
    end else if (line_buffer_reset) begin
      // Clear wins over a pixel presented in the same cycle.
      // data_out keeps its last value.
      state_r   <= ST_CLEAR;
      col_r     <= 16'd0;
      h_cnt_r   <= 8'd0;
      v_cnt_r   <= 8'd0;
      wcol_r    <= {WCW{1'b0}};
      hmax_r    <= {PW{1'b0}};
      out_valid <= 1'b0;
      out_cnt   <= 16'd0;
      cfg_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (cfg_ok_s) begin
            state_r <= ST_RUN;
            cfg_err <= 1'b0;
          end else begin
            state_r <= ST_ERR;
            cfg_err <= 1'b1;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          cfg_err <= 1'b0;
        end
        ST_ERR: begin
          state_r <= ST_ERR;
          cfg_err <= 1'b1;
        end
        default: begin
          state_r <= ST_CLEAR;
          cfg_err <= 1'b0;
        end
      endcase

      out_valid <= emit_s;
      if (emit_s) begin
        data_out <= result_s;
        out_cnt  <= out_cnt + 16'd1;
      end

      if (accept_s) begin
        hmax_r <= h_val_s;
        if (row_end_s) begin
          col_r   <= 16'd0;
          h_cnt_r <= 8'd0;
          wcol_r  <= {WCW{1'b0}};
          // Trailing rows that do not fill a band are folded into the next wrap.
          // They are never emitted.
          if (v_last_s) begin
            v_cnt_r <= 8'd0;
          end else begin
            v_cnt_r <= v_cnt_r + 8'd1;
          end
        end else begin
          col_r <= col_r + 16'd1;
          // A trailing partial window never reaches h_done before the row ends.
          // Its pixels therefore never reach pbuf.
          if (h_done_s) begin
            h_cnt_r <= 8'd0;
            wcol_r  <= wcol_r + WCW'(1);
          end else begin
            h_cnt_r <= h_cnt_r + 8'd1;
          end
        end
      end
    end
  end

  // Partial column buffer.
  // Each window column's entry is written when its horizontal span completes.
  always_ff @(posedge clk) begin
    if (accept_s && h_done_s) begin
      pbuf[wcol_r] <= comb_s;
    end
  end

endmodule

// File: tb/tb_pool_window_unit.sv
// Testbench for pool_window_unit.
// The driver pushes expected results into a scoreboard queue.
// A negedge monitor pops an entry for every out_valid pulse.
// It checks each entry's value and the cycle it appears in.
// Expected values are computed directly from an image array.
// Each one is the max or the average over the window's pixels.
module tb_pool_window_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pool_enable;
  logic        line_buffer_reset;
  logic        shift_in;
  logic [15:0] data_in;
  logic [15:0] row_length;
  logic [7:0]  pool_horiz;
  logic [7:0]  pool_vert;
  logic [15:0] data_out;
  logic        out_valid;
  logic [15:0] out_cnt;
  logic        cfg_err;
  bit          avg_sel = 1'b0;
`ifdef POOL_AVG_EN
  logic        pool_avg;
  assign pool_avg = avg_sel;
`endif

  pool_window_unit dut (
    .clk               (clk),
    .rst               (rst),
    .pool_enable       (pool_enable),
    .line_buffer_reset (line_buffer_reset),
    .shift_in          (shift_in),
    .data_in           (data_in),
    .row_length        (row_length),
    .pool_horiz        (pool_horiz),
    .pool_vert         (pool_vert),
`ifdef POOL_AVG_EN
    .pool_avg          (pool_avg),
`endif
    .data_out          (data_out),
    .out_valid         (out_valid),
    .out_cnt           (out_cnt),
    .cfg_err           (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int at;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   img[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Monitor: every out_valid pulse must match the oldest expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid === 1'b1) begin
      chk("out_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data_out", {16'd0, data_out}, {16'd0, 16'(e.val)});
        chk("latency_cycle", cyc, e.at);
      end
    end
  end

  // Reference: max or floor-average over the window whose bottom-right pixel is (r,c).
  function automatic int ref_window(int r, int c, int w, int ph, int pv, bit avg);
    int best, sum, sh;
    best = img[(r - pv + 1) * w + (c - ph + 1)];
    sum  = 0;
    for (int i = r - pv + 1; i <= r; i++) begin
      for (int j = c - ph + 1; j <= c; j++) begin
        if (img[i * w + j] > best) best = img[i * w + j];
        sum += img[i * w + j];
      end
    end
    if (!avg) return best;
    sh = 0;
    while ((1 << sh) < ph * pv) sh++;
    return sum >>> sh;
  endfunction

  task automatic fill_image(input int mode, input int n, input int w);
    for (int k = 0; k < n; k++) begin
      if (mode == 0) img[k] = k;
      else if (mode == 1) img[k] = (k == w + 1) ? -1 : -3;
      else img[k] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  task automatic send_pixel(input int v, input bit has_exp, input int ev);
    shift_in    = 1'b1;
    pool_enable = 1'b1;
    data_in     = 16'(v);
    if (has_exp) sb.push_back('{val: ev, at: cyc + 1});
    @(negedge clk);
    shift_in = 1'b0;
    data_in  = 16'($urandom);
  endtask

  // Idle cycles: either no pixel, or a pixel offered while pool_enable is low.
  task automatic idle(input int n, input bit stall_enable);
    for (int i = 0; i < n; i++) begin
      if (stall_enable) begin
        shift_in = 1'b1; pool_enable = 1'b0; data_in = 16'($urandom);
      end else begin
        shift_in = 1'b0; pool_enable = 1'b1;
      end
      @(negedge clk);
    end
    shift_in    = 1'b0;
    pool_enable = 1'b1;
  endtask

  // gap_mode: 0 back-to-back, 1 every other cycle plus a 3-cycle enable stall, 2 random.
  task automatic run_case(input int w, input int h, input int ph, input int pv, input bit avg,
                          input int img_mode, input int gap_mode, input int npix,
                          input bit do_clear);
    int r, c;
    bit hit;
    fill_image(img_mode, w * h, w);
    row_length = 16'(w);
    pool_horiz = 8'(ph);
    pool_vert  = 8'(pv);
    avg_sel    = avg;
    if (do_clear) begin
      line_buffer_reset = 1'b1;
      @(negedge clk);
      line_buffer_reset = 1'b0;
      @(negedge clk);
      chk("cfg_err_legal", {31'd0, cfg_err}, 32'd0);
    end
    for (int k = 0; k < npix; k++) begin
      r   = k / w;
      c   = k % w;
      hit = (((c + 1) % ph) == 0) && (((r + 1) % pv) == 0);
      if (gap_mode == 1) begin
        if (k > 0) idle(1, 1'b0);
        if (k == 6) idle(3, 1'b1);
      end else if (gap_mode == 2) begin
        idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end
      send_pixel(img[k], hit, hit ? ref_window(r, c, w, ph, pv, avg) : 0);
    end
    if (npix == w * h) begin
      chk("out_cnt_final", {16'd0, out_cnt}, 32'((w / ph) * (h / pv)));
      // Clear with a pixel in the same cycle: the pixel is dropped.
      line_buffer_reset = 1'b1;
      shift_in          = 1'b1;
      data_in           = 16'($urandom);
      @(negedge clk);
      shift_in = 1'b0;
      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      chk("out_cnt_cleared", {16'd0, out_cnt}, 32'd0);
    end
  endtask

  task automatic cfg_case(input int w, input int ph, input int pv, input bit avg);
    row_length = 16'(w);
    pool_horiz = 8'(ph);
    pool_vert  = 8'(pv);
    avg_sel    = avg;
    line_buffer_reset = 1'b1;
    @(negedge clk);
    line_buffer_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("cfg_err_set", {31'd0, cfg_err}, 32'd1);
    for (int k = 0; k < 8; k++) send_pixel(int'($urandom_range(0, 65535)), 1'b0, 0);
    chk("cfg_err_no_output", {16'd0, out_cnt}, 32'd0);
    line_buffer_reset = 1'b1;
    @(negedge clk);
    chk("cfg_err_cleared", {31'd0, cfg_err}, 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph, pv, w, h;
    rst = 1'b1; pool_enable = 1'b1; line_buffer_reset = 1'b1; shift_in = 1'b0;
    data_in = 16'd0; row_length = 16'd4; pool_horiz = 8'd2; pool_vert = 8'd2;
    @(negedge clk);
    @(negedge clk);
    chk("reset_data_out", {16'd0, data_out}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_cnt", {16'd0, out_cnt}, 32'd0);
    chk("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_case(4, 4, 2, 2, 1'b0, 0, 0, 16, 1'b1);   // ramp -> 5,7,13,15
    run_case(5, 5, 2, 2, 1'b0, 1, 0, 25, 1'b1);   // -1,-3,-3,-3, edge col/row dropped
    run_case(4, 4, 2, 2, 1'b0, 0, 1, 16, 1'b1);   // gaps and enable stall

    cfg_case(4, 0, 2, 1'b0);
    cfg_case(2, 3, 2, 1'b0);
    cfg_case(4, 2, 9, 1'b0);
    cfg_case(65, 2, 2, 1'b0);

    // Async reset mid-row, then a run that starts without a line_buffer_reset.
    run_case(4, 4, 2, 2, 1'b0, 0, 0, 6, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_out_cnt", {16'd0, out_cnt}, 32'd0);
    chk("async_rst_data_out", {16'd0, data_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    line_buffer_reset = 1'b0;
    run_case(4, 4, 2, 2, 1'b0, 0, 0, 16, 1'b0);

    run_case(64, 2, 8, 2, 1'b0, 2, 0, 128, 1'b1); // widest row, largest window width
    run_case(16, 8, 8, 8, 1'b0, 2, 2, 128, 1'b1); // largest window
    for (int t = 0; t < 20; t++) begin
      ph = int'($urandom_range(1, 4));
      pv = int'($urandom_range(1, 4));
      w  = int'($urandom_range(ph, 12));
      h  = int'($urandom_range(1, 10));
      run_case(w, h, ph, pv, 1'b0, 2, 2, w * h, 1'b1);
    end

`ifdef POOL_AVG_EN
    run_case(4, 4, 2, 2, 1'b1, 0, 0, 16, 1'b1);   // 2,4,10,12
    cfg_case(4, 3, 1, 1'b1);
    for (int t = 0; t < 8; t++) begin
      ph = 1 << $urandom_range(0, 2);
      pv = 1 << $urandom_range(0, 2);
      w  = int'($urandom_range(ph, 12));
      h  = int'($urandom_range(1, 10));
      run_case(w, h, ph, pv, 1'b1, 2, 2, w * h, 1'b1);
    end
    avg_sel = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pool_window_unit.md
# pool_window_unit

Per-PE max-pool datapath that consumes the raster pixel stream shifted into a PE by the pool controller and produces one pooled value per non-overlapping `pool_horiz` x `pool_vert` window. It keeps a horizontal running maximum plus a one-row buffer of partial column maxima, and emits results with a fixed 1-cycle latency. The result goes to the PE output mux for write-back into BUF2. One instance sits in each PE, directly downstream of the pool controller's `shifting_line` / `line_buffer_reset` controls.

## Interface
- `DATA_W`, 16: signed pixel width.
- `MAX_ROW`, 64: maximum supported `row_length`; sets the partial-row buffer depth.
- `MAX_POOL`, 8: maximum `pool_horiz` / `pool_vert`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pool_enable`  in  1  block active; when 0, `shift_in` is ignored.
- `line_buffer_reset`  in  1  synchronous clear of all counters and buffers; held high between channel blocks.
- `shift_in`  in  1  one pixel presented this cycle.
- `data_in`  in  DATA_W  signed pixel, raster order.
- `row_length`  in  16  input row width.
- `pool_horiz`  in  8  window width.
- `pool_vert`  in  8  window height.
- `data_out`  out  DATA_W  pooled result; reset value 0.
- `out_valid`  out  1  `data_out` valid this cycle; reset value 0.
- `out_cnt`  out  16  results emitted since the last clear; reset value 0, wraps at 2^16.
- `cfg_err`  out  1  registered config-illegal flag; reset value 0.

## Operation
- States: CLEAR, RUN, ERR.
  - CLEAR is entered on `rst` or while `line_buffer_reset`=1.
  - CLEAR -> RUN when `line_buffer_reset` falls and the config is legal.
  - CLEAR -> ERR when `line_buffer_reset` falls and the config is illegal.
  - ERR -> CLEAR only via `line_buffer_reset` or `rst`.
- Illegal config is any of:
  - `pool_horiz`=0 or `pool_vert`=0;
  - `pool_horiz`>MAX_POOL or `pool_vert`>MAX_POOL;
  - `row_length`>MAX_ROW;
  - `row_length`<`pool_horiz`.
- In ERR, `cfg_err`=1 and no results are produced.
- Config inputs must be stable while `line_buffer_reset`=0; changing them mid-run is undefined.
- Counters: `col` (0..row_length-1), `h_cnt` (0..pool_horiz-1), `v_cnt` (0..pool_vert-1), `wcol` (window column index). All advance only on an accepted pixel (`shift_in`=1, `pool_enable`=1, RUN).
- Horizontal pass:
  - `hmax` = `data_in` when `h_cnt`=0, else max(`hmax`, `data_in`).
  - When `h_cnt`=pool_horiz-1 the horizontal max is complete for window column `wcol`.
- Vertical pass, on horizontal completion:
  - `v_cnt`=0: `pbuf[wcol]` <= horizontal max.
  - 0<`v_cnt`<pool_vert-1: `pbuf[wcol]` <= max(`pbuf[wcol]`, horizontal max).
  - `v_cnt`=pool_vert-1: result = max(`pbuf[wcol]`, horizontal max), emitted.
- End of row: when `col`=row_length-1, `col`, `h_cnt` and `wcol` reset to 0 and `v_cnt` advances, wrapping at pool_vert-1.
- Trailing partial data is dropped with no output, so output dims are floor(wid/horiz) x floor(hei/vert):
  - pixels past the last full window column are accepted but never enter `pbuf`;
  - trailing rows short of a full `pool_vert` band are accumulated but never emitted.
- All compares are signed, two's complement. Max picks either operand on a tie; the result is identical.

## Timing
- Latency: the result of a window appears on `data_out` with `out_valid`=1 exactly 1 cycle after the accepted pixel that completes it (LAT_POOL=1).
- `out_valid` is a single-cycle pulse. `data_out` holds its last value otherwise.
- Throughput: 1 pixel per cycle, no stalls, no backpressure. Gaps in `shift_in` are allowed anywhere.
- `line_buffer_reset`=1 together with `shift_in`=1: reset wins, the pixel is dropped, and any pending `out_valid` from the previous cycle still fires.
- `pool_enable`=0 freezes all counters and buffers; state resumes unchanged when it returns to 1.
- `rst` mid-row clears all state and outputs asynchronously. `pbuf` contents need not be cleared; `v_cnt`=0 overwrites them.
- `out_cnt` increments in the same cycle `out_valid`=1.

## Configuration
- `POOL_AVG_EN` defined:
  - adds input port `pool_avg` (1 bit);
  - when `pool_avg`=1, max is replaced by summation in a DATA_W+6-bit signed accumulator, and the result is sum >>> log2(pool_horiz*pool_vert), arithmetic, truncated to DATA_W;
  - with `pool_avg`=1, a window area that is not a power of two is an illegal config and raises `cfg_err`.
- `POOL_AVG_EN` undefined: the port is absent, only max pooling exists, and `pbuf` is DATA_W wide.

## Test plan
- 4x4 input, values 0..15 raster, pool 2x2, row 4 -> 4 pulses with `data_out`=5,7,13,15; each 1 cycle after pixels 5,7,13,15 respectively; final `out_cnt`=4.
- 5x5 input, all -3 except pixel (1,1)=-1, pool 2x2 -> exactly 4 outputs: -1,-3,-3,-3. Column 4 and row 4 are dropped.
- 4x4 ramp with `shift_in` toggling every other cycle and `pool_enable` low for 3 cycles mid-row -> same 4 results as the first case, each 1 cycle after its completing pixel.
- `pool_horiz`=0, or `row_length`=2 with `pool_horiz`=3 -> `cfg_err`=1 after `line_buffer_reset` falls, no `out_valid`. Raising `line_buffer_reset` clears `cfg_err`.
- Async `rst` after 6 pixels, then a clean 4x4 2x2 run -> identical to the first case, no stale partial results.
- `POOL_AVG_EN`, `pool_avg`=1, 2x2 on 0..15 -> 2,4,10,12. With 3x1 pooling -> `cfg_err`=1.
